// File: rtl/imm_gen_pkg.sv
// Shared immediate-type encodings and the XLEN legality check for the immediate generator.
package imm_gen_pkg;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_U    = 3'b101;
  localparam logic [2:0] IMM_Z    = 3'b110;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate decode: (inst, sel) -> sign-extended XLEN immediate plus illegal flag.
// Build option IMM_GEN_ZIMM_EN enables the CSR zimm select (110); otherwise 110 is illegal.
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [2:0]      sel_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic signed [31:0] raw;
  logic               unused_opcode;

  // The opcode field never contributes to an immediate.
  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    raw       = '0;
    illegal_o = 1'b0;
    case (sel_i)
      IMM_NONE: raw = '0;
      IMM_I:    raw = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:    raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:    raw = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_J:    raw = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      IMM_U:    raw = {inst_i[31:12], 12'b0};
      IMM_Z: begin
`ifdef IMM_GEN_ZIMM_EN
        raw = {27'b0, inst_i[19:15]};
`else
        illegal_o = 1'b1;
`endif
      end
      default:  illegal_o = 1'b1;
    endcase
  end

  // raw is 32-bit signed, so widening to 64 replicates bit 31 (zimm keeps bit 31 clear).
  assign imm_o = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main output register plus one skid entry;
// in_ready depends only on registered state. Optional zimm via IMM_GEN_ZIMM_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  core_imm;
  logic             core_ill;

  logic             main_vld_q, main_vld_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic             main_ill_q, main_ill_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             push, pop;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .inst_i    (in_inst),
    .sel_i     (in_imm_sel),
    .imm_o     (core_imm),
    .illegal_o (core_ill)
  );

  assign in_ready = ~skid_vld_q;
  assign push     = in_valid & ~skid_vld_q;
  assign pop      = main_vld_q & out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_ill_d = main_ill_q;
    main_tag_d = main_tag_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;
    if (pop) begin
      // A full skid blocks push, so refill from skid takes priority.
      if (skid_vld_q) begin
        main_imm_d = skid_imm_q;
        main_ill_d = skid_ill_q;
        main_tag_d = skid_tag_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_imm_d = core_imm;
        main_ill_d = core_ill;
        main_tag_d = in_tag;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      if (main_vld_q) begin
        skid_vld_d = 1'b1;
        skid_imm_d = core_imm;
        skid_ill_d = core_ill;
        skid_tag_d = in_tag;
      end else begin
        main_vld_d = 1'b1;
        main_imm_d = core_imm;
        main_ill_d = core_ill;
        main_tag_d = in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_ill_q <= 1'b0;
      main_tag_q <= '0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
      skid_tag_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_ill_q <= main_ill_d;
      main_tag_q <= main_tag_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
      skid_tag_q <= skid_tag_d;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_imm     = main_imm_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;

endmodule
